aim_pair_streamer: RTL

Downstream consumer of the associative-index-matching stage. Snapshots the per-weight match vector (valid flag + 9-bit IA position per compressed weight entry) when that stage finishes, then streams the matched (weight index, IA position) pairs in ascending weight-index order, one per cycle, over a valid/ready handshake into the sparse MAC datapath. Unmatched entries are skipped. A done pulse and a pair count are produced per frame.

---
 rtl/aim_pair_streamer.sv | 117 +++++++++++
 1 files changed

// File: rtl/aim_pair_streamer.sv
// Snapshots the per-entry match vector and streams matched (index, position)
// pairs in ascending index order over a valid/ready handshake.
module aim_pair_streamer #(
    parameter int N_ENTRIES = 64,
    parameter int POS_W     = 9,
    parameter int IDX_W     = $clog2(N_ENTRIES)
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_start,
    input  logic [IDX_W:0]             i_n,
    input  logic [N_ENTRIES-1:0]       i_valid,
    input  logic [N_ENTRIES*POS_W-1:0] i_pos,
    output logic                       o_pair_valid,
    input  logic                       i_pair_ready,
    output logic [IDX_W-1:0]           o_w_idx,
    output logic [POS_W-1:0]           o_ia_pos,
    output logic                       o_last,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [IDX_W:0]             o_count
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [IDX_W:0] N_MAX = (IDX_W+1)'(N_ENTRIES);

    state_t                     state;
    logic [N_ENTRIES-1:0]       mask_r;
    logic [N_ENTRIES-1:0]       mask_in;
    logic [N_ENTRIES-1:0]       rest;
    logic [N_ENTRIES*POS_W-1:0] pos_r;
    logic [IDX_W:0]             cnt;
    logic [IDX_W:0]             n_eff;
    logic [IDX_W-1:0]           sel;
    logic                       found;
    logic                       others;
    logic                       hs;
    logic                       load;
    logic                       finish;

    always_comb begin
        n_eff = (i_n > N_MAX) ? N_MAX : i_n;
        mask_in = '0;
        for (int k = 0; k < N_ENTRIES; k++) begin
            mask_in[k] = i_valid[k] && ((IDX_W+1)'(k) < n_eff);
        end
    end

    // Lowest set bit wins: scan downward so the last hit is the smallest index.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int k = N_ENTRIES - 1; k >= 0; k--) begin
            if (mask_r[k]) begin
                sel   = IDX_W'(k);
                found = 1'b1;
            end
        end
        rest      = mask_r;
        rest[sel] = 1'b0;
        others    = |rest;
    end

    assign hs     = o_pair_valid & i_pair_ready;
    assign load   = (state == S_RUN) && found && (!o_pair_valid || hs);
    assign finish = (hs && o_last) || (!o_pair_valid && !found);
    assign o_busy = (state == S_RUN);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            mask_r       <= '0;
            pos_r        <= '0;
            cnt          <= '0;
            o_pair_valid <= 1'b0;
            o_w_idx      <= '0;
            o_ia_pos     <= '0;
            o_last       <= 1'b0;
            o_done       <= 1'b0;
            o_count      <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        mask_r <= mask_in;
                        pos_r  <= i_pos;
                        cnt    <= '0;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (hs) cnt <= cnt + 1'b1;
                    if (load) begin
                        o_w_idx      <= sel;
                        o_ia_pos     <= pos_r[sel*POS_W +: POS_W];
                        o_pair_valid <= 1'b1;
                        o_last       <= !others;
                        mask_r[sel]  <= 1'b0;
                    end else if (hs) begin
                        o_pair_valid <= 1'b0;
                    end
                    if (finish) begin
                        state        <= S_IDLE;
                        o_done       <= 1'b1;
                        o_count      <= hs ? cnt + 1'b1 : cnt;
                        o_pair_valid <= 1'b0;
                        o_last       <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
